// File: rtl/conv_word_ser.sv
// Word-to-byte serializer feeding a byte-wide UART transmitter: snapshots a word,
// then hands it out one byte per tx_start / tx_done_tick handshake.
module conv_word_ser #(
  parameter int NBYTES     = 5,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          control,
  input  logic                          abort,
  input  logic [8*NBYTES-1:0]           din,
  input  logic [$clog2(NBYTES+1)-1:0]   len,
  input  logic                          tx_done_tick,
  output logic [7:0]                    adout,
  output logic                          tx_start,
  output logic                          tx_done,
  output logic                          busy
);

  localparam int         CW       = $clog2(NBYTES+1);
  localparam int         DW       = 8*NBYTES;
  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_GAP, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] shreg_q, shreg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    gap_q, gap_d;
  logic [7:0]    adout_d;

  // The byte at the output end of the shift register is always the one on the wire.
  function automatic logic [7:0] head_byte(input logic [DW-1:0] w);
    return MSB_FIRST ? w[DW-1 -: 8] : w[7:0];
  endfunction

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    case (state_q)
      S_IDLE: begin
        if (control) begin
          shreg_d = din;
          cnt_d   = (len == '0 || len > CW'(NBYTES)) ? CW'(NBYTES) : len;
          state_d = S_START;
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (tx_done_tick) begin
          if (cnt_q == CW'(1)) begin
            state_d = S_DONE;
          end else begin
            shreg_d = MSB_FIRST ? (shreg_q << 8) : (shreg_q >> 8);
            cnt_d   = cnt_q - CW'(1);
            if (GAP_CYCLES > 0) begin
              gap_d   = GAP_LOAD;
              state_d = S_GAP;
            end else begin
              state_d = S_START;
            end
          end
        end
      end
      S_GAP: begin
        if (gap_q == '0) state_d = S_START;
        else             gap_d   = gap_q - 8'd1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort overrides any handshake in flight; DONE is allowed to finish.
    if (abort && (state_q inside {S_START, S_WAIT, S_GAP})) begin
      state_d = S_IDLE;
      shreg_d = '0;
      cnt_d   = '0;
      gap_d   = '0;
    end
  end

  // Outputs are computed from the next state so they leave a flop aligned with it.
  always_comb begin
    adout_d = (state_d inside {S_START, S_WAIT, S_GAP}) ? head_byte(shreg_d) : 8'h00;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
      gap_q    <= '0;
      adout    <= 8'h00;
      tx_start <= 1'b0;
      tx_done  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample pre-edge values,
      // so the order of these lines does not matter.
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      gap_q    <= gap_d;
      adout    <= adout_d;
      tx_start <= (state_d == S_START);
      tx_done  <= (state_d == S_DONE);
      busy     <= (state_d != S_IDLE);
    end
  end

endmodule

// File: tb/tb_conv_word_ser.sv
// Bench for conv_word_ser: two instances (MSB-first/no gap, LSB-first/gap 4) checked
// every cycle against a word-level model, plus literal byte sequences and timings.
module tb_conv_word_ser;

  localparam int N = 5;

  logic        clk;
  logic        reset;
  logic        control;
  logic        abort;
  logic [39:0] din;
  logic [2:0]  len;
  logic [1:0]  tick;
  logic [7:0]  adout [2];
  logic [1:0]  tx_start;
  logic [1:0]  tx_done;
  logic [1:0]  busy;

  conv_word_ser #(.NBYTES(N), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) u_msb (
    .clk(clk), .reset(reset), .control(control), .abort(abort), .din(din), .len(len),
    .tx_done_tick(tick[0]), .adout(adout[0]), .tx_start(tx_start[0]),
    .tx_done(tx_done[0]), .busy(busy[0])
  );

  conv_word_ser #(.NBYTES(N), .MSB_FIRST(1'b0), .GAP_CYCLES(4)) u_lsb (
    .clk(clk), .reset(reset), .control(control), .abort(abort), .din(din), .len(len),
    .tx_done_tick(tick[1]), .adout(adout[1]), .tx_start(tx_start[1]),
    .tx_done(tx_done[1]), .busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- word-level reference model ----------------
  logic [39:0] m_word  [2];
  int          m_cnt   [2];
  int          m_k     [2];
  int          m_gap   [2];
  bit          m_busy  [2];
  bit          m_start [2];
  bit          m_wait  [2];
  bit          m_done  [2];

  function automatic int gap_of(input int d);
    return (d == 0) ? 0 : 4;
  endfunction

  function automatic logic [7:0] exp_byte(input int d);
    int b;
    b = (d == 0) ? (N - 1 - m_k[d]) : m_k[d];
    return m_word[d][8*b +: 8];
  endfunction

  task automatic model_clear(input int d);
    m_busy[d] = 0; m_start[d] = 0; m_wait[d] = 0; m_done[d] = 0;
    m_gap[d] = 0; m_k[d] = 0; m_cnt[d] = 0;
  endtask

  task automatic model_step(input int d);
    if (m_done[d]) begin
      m_done[d] = 0;
      m_busy[d] = 0;
    end else if (!m_busy[d]) begin
      if (control) begin
        m_word[d]  = din;
        m_cnt[d]   = (len == 0 || int'(len) > N) ? N : int'(len);
        m_k[d]     = 0;
        m_busy[d]  = 1;
        m_start[d] = 1;
      end
    end else if (abort) begin
      model_clear(d);
    end else if (m_start[d]) begin
      m_start[d] = 0;
      m_wait[d]  = 1;
    end else if (m_wait[d]) begin
      if (tick[d]) begin
        m_wait[d] = 0;
        if (m_k[d] == m_cnt[d] - 1) begin
          m_done[d] = 1;
        end else begin
          m_k[d]++;
          if (gap_of(d) > 0) m_gap[d] = gap_of(d);
          else               m_start[d] = 1;
        end
      end
    end else if (m_gap[d] > 0) begin
      m_gap[d]--;
      if (m_gap[d] == 0) m_start[d] = 1;
    end
  endtask

  always @(posedge clk or negedge reset) begin
    for (int d = 0; d < 2; d++) begin
      if (!reset) model_clear(d);
      else        model_step(d);
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        logic [7:0] eb;
        eb = (m_start[d] || m_wait[d] || m_gap[d] > 0) ? exp_byte(d) : 8'h00;
        check($sformatf("adout[%0d]", d), adout[d], eb);
        check($sformatf("tx_start[%0d]", d), tx_start[d], m_start[d]);
        check($sformatf("tx_done[%0d]", d), tx_done[d], m_done[d]);
        check($sformatf("busy[%0d]", d), busy[d], m_busy[d]);
      end
    end
  end

  // ---------------- UART transmitter stand-in and recorders ----------------
  int  cyc = 0;
  int  cd [2];
  int  last_start [2];
  int  last_gap [2];
  int  lat_fixed = 10;
  bit  spur_en   = 1'b0;
  logic [7:0] got0 [$];
  logic [7:0] got1 [$];
  int  done_cnt [2];

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    for (int d = 0; d < 2; d++) begin
      logic t;
      t = 1'b0;
      if (!reset) begin
        cd[d] = 0;
      end else begin
        if (cd[d] > 0) begin
          cd[d]--;
          if (cd[d] == 0) t = 1'b1;
        end
        if (tx_start[d]) begin
          cd[d] = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 6));
          if (spur_en && $urandom_range(0, 2) == 0) t = 1'b1;
          if (last_start[d] >= 0) last_gap[d] = cyc - last_start[d];
          last_start[d] = cyc;
        end
        if (spur_en && $urandom_range(0, 15) == 0) t = 1'b1;
      end
      tick[d] = t;
    end
  end

  always @(negedge clk) begin
    if (tx_start[0]) got0.push_back(adout[0]);
    if (tx_start[1]) got1.push_back(adout[1]);
    if (tx_done[0])  done_cnt[0]++;
    if (tx_done[1])  done_cnt[1]++;
  end

  // ---------------- directed helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_rec();
    got0.delete();
    got1.delete();
    for (int d = 0; d < 2; d++) begin
      done_cnt[d]   = 0;
      last_start[d] = -1;
      last_gap[d]   = 0;
    end
  endtask

  task automatic send_word(input logic [39:0] w, input logic [2:0] l);
    din     = w;
    len     = l;
    control = 1'b1;
    step();
    control = 1'b0;
  endtask

  task automatic wait_words();
    for (int i = 0; i < 600 && !(done_cnt[0] >= 1 && done_cnt[1] >= 1); i++) step();
    step(); step();
    check("done_pulses0", done_cnt[0], 1);
    check("done_pulses1", done_cnt[1], 1);
    check("busy_after0", busy[0], 1'b0);
    check("busy_after1", busy[1], 1'b0);
  endtask

  task automatic check_bytes(input int d, input logic [39:0] e, input int n);
    int sz;
    sz = (d == 0) ? got0.size() : got1.size();
    check($sformatf("nbytes%0d", d), sz, n);
    for (int i = 0; i < n && i < sz; i++)
      check($sformatf("byte%0d[%0d]", d, i), (d == 0) ? got0[i] : got1[i], e[8*(n-1-i) +: 8]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int sz0, sz1;
    bit hold;
    reset   = 1'b0;
    control = 1'b0;
    abort   = 1'b0;
    din     = '0;
    len     = '0;
    tick    = '0;
    clear_rec();
    repeat (3) step();
    chk_en = 1'b1;
    reset  = 1'b1;
    step();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_adout%0d", d), adout[d], 8'h00);
      check($sformatf("rst_busy%0d", d), busy[d], 1'b0);
      check($sformatf("rst_tx_start%0d", d), tx_start[d], 1'b0);
    end

    // Full word, len=0, with din overwritten after capture.
    clear_rec();
    send_word(40'h1122334455, 3'd0);
    din = '1;
    wait_words();
    check_bytes(0, 40'h1122334455, 5);
    check_bytes(1, 40'h5544332211, 5);
    check("start_spacing0", last_gap[0], 11);
    check("start_spacing1", last_gap[1], 15);

    // Short word.
    clear_rec();
    send_word(40'h1122334455, 3'd3);
    wait_words();
    check_bytes(0, 40'h112233, 3);
    check_bytes(1, 40'h554433, 3);

    // Oversized length falls back to the full word.
    clear_rec();
    send_word(40'hA1B2C3D4E5, 3'd7);
    wait_words();
    check_bytes(0, 40'hA1B2C3D4E5, 5);
    check_bytes(1, 40'hE5D4C3B2A1, 5);

    // Abort in WAIT of byte 2, in the same cycle as its tick.
    clear_rec();
    send_word(40'h6677889900, 3'd0);
    for (int i = 0; i < 200 && !(got0.size() >= 2 && tick[0]); i++) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy0", busy[0], 1'b0);
    check("abort_adout0", adout[0], 8'h00);
    repeat (30) step();
    check("abort_no_done0", done_cnt[0], 0);
    clear_rec();
    send_word(40'h0102030405, 3'd0);
    wait_words();
    check_bytes(0, 40'h0102030405, 5);

    // Asynchronous reset between edges while waiting for a tick.
    clear_rec();
    send_word(40'hCAFEBABE42, 3'd0);
    for (int i = 0; i < 100 && got0.size() < 1; i++) step();
    repeat (3) step();
    #1 reset = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("arst_adout%0d", d), adout[d], 8'h00);
      check($sformatf("arst_tx_start%0d", d), tx_start[d], 1'b0);
      check($sformatf("arst_busy%0d", d), busy[d], 1'b0);
    end
    repeat (2) step();
    reset = 1'b1;
    sz0 = got0.size();
    sz1 = got1.size();
    repeat (20) step();
    check("post_rst_starts0", got0.size(), sz0);
    check("post_rst_starts1", got1.size(), sz1);

    // Randomized traffic: spurious ticks, held control, aborts, changing din/len.
    spur_en   = 1'b1;
    lat_fixed = 0;
    hold      = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) hold = ($urandom_range(0, 2) == 0);
      control = hold ? 1'b1 : ($urandom_range(0, 3) == 0);
      abort   = ($urandom_range(0, 39) == 0);
      din     = {8'($urandom), 32'($urandom)};
      len     = 3'($urandom_range(0, 7));
      step();
    end
    control = 1'b0;
    abort   = 1'b0;
    repeat (5) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
